// File: rtl/alu_instr_sequencer_pkg.sv
// Shared encodings for the ALU instruction sequencer: ALU control words,
// instruction opcode/opExt fields, FSM states and the decoder result struct.
// Imported by the interface, the decoder and the sequencer top.
package alu_instr_sequencer_pkg;

    // ALU control words understood by the cpu datapath
    localparam logic [3:0] CONTROL_ADD  = 4'b0000;
    localparam logic [3:0] CONTROL_ADDU = 4'b0001;
    localparam logic [3:0] CONTROL_SUB  = 4'b0010;
    localparam logic [3:0] CONTROL_SUBU = 4'b0011;
    localparam logic [3:0] CONTROL_CMP  = 4'b0100;
    localparam logic [3:0] CONTROL_AND  = 4'b0101;
    localparam logic [3:0] CONTROL_OR   = 4'b0110;
    localparam logic [3:0] CONTROL_XOR  = 4'b0111;
    localparam logic [3:0] CONTROL_LSH  = 4'b1000;

    // Instruction opcode field [15:12]
    localparam logic [3:0] OPCODE_REG   = 4'b0000;
    localparam logic [3:0] OPCODE_SHIFT = 4'b1000;

    // Instruction opExt field [7:4]
    localparam logic [3:0] OPEXT_ADD  = 4'b0101;
    localparam logic [3:0] OPEXT_ADDU = 4'b0110;
    localparam logic [3:0] OPEXT_SUB  = 4'b1001;
    localparam logic [3:0] OPEXT_SUBU = 4'b1010;
    localparam logic [3:0] OPEXT_CMP  = 4'b1011;
    localparam logic [3:0] OPEXT_AND  = 4'b0001;
    localparam logic [3:0] OPEXT_OR   = 4'b0010;
    localparam logic [3:0] OPEXT_XOR  = 4'b0011;
    localparam logic [3:0] OPEXT_LSH  = 4'b0100;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       writes_reg;
        logic       legal;
    } decode_t;

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Instruction handshake plus datapath control bundle of the sequencer.
// master: instruction producer / observer side; slave: the sequencer.
// Widths follow the sequencer's REG_ADDR_BITS and COUNT_WIDTH.
interface alu_instr_sequencer_if #(
    parameter int REG_ADDR_BITS = 3,
    parameter int COUNT_WIDTH   = 16
);
    logic                     instrValid;
    logic [15:0]              instr;
    logic                     instrReady;
    logic [3:0]               aluControl;
    logic [REG_ADDR_BITS-1:0] regAddressA;
    logic [REG_ADDR_BITS-1:0] regAddressB;
    logic                     regWriteEnable;
    logic                     flagWriteEnable;
    logic                     busy;
    logic                     illegalInstr;
    logic [COUNT_WIDTH-1:0]   retireCount;
    logic                     halted;

    modport master (
        output instrValid, instr,
        input  instrReady, aluControl, regAddressA, regAddressB,
               regWriteEnable, flagWriteEnable, busy, illegalInstr,
               retireCount, halted
    );

    modport slave (
        input  instrValid, instr,
        output instrReady, aluControl, regAddressA, regAddressB,
               regWriteEnable, flagWriteEnable, busy, illegalInstr,
               retireCount, halted
    );
endinterface

// File: rtl/alu_instr_sequencer_decode.sv
// Combinational decode of {opcode, opExt} into ALU control, write-back need and legality.
// Latency: zero cycles (pure combinational).
// Backpressure: none; evaluated whenever the sequencer samples it.
import alu_instr_sequencer_pkg::*;

module alu_instr_decode (
    input  logic [3:0] opcode,
    input  logic [3:0] opext,
    output decode_t    dec
);
    // Map the supported register-format instructions; anything else is illegal
    always_comb begin
        dec = '{alu_control: CONTROL_ADD, writes_reg: 1'b0, legal: 1'b0};
        if (opcode == OPCODE_REG) begin
            dec.legal      = 1'b1;
            dec.writes_reg = 1'b1;
            case (opext)
                OPEXT_ADD:  dec.alu_control = CONTROL_ADD;
                OPEXT_ADDU: dec.alu_control = CONTROL_ADDU;
                OPEXT_SUB:  dec.alu_control = CONTROL_SUB;
                OPEXT_SUBU: dec.alu_control = CONTROL_SUBU;
                OPEXT_CMP: begin
                    dec.alu_control = CONTROL_CMP;
                    dec.writes_reg  = 1'b0;   // compare only updates flags
                end
                OPEXT_AND:  dec.alu_control = CONTROL_AND;
                OPEXT_OR:   dec.alu_control = CONTROL_OR;
                OPEXT_XOR:  dec.alu_control = CONTROL_XOR;
                default: begin
                    dec.legal      = 1'b0;
                    dec.writes_reg = 1'b0;
                end
            endcase
        end else if (opcode == OPCODE_SHIFT && opext == OPEXT_LSH) begin
            dec.alu_control = CONTROL_LSH;
            dec.writes_reg  = 1'b1;
            dec.legal       = 1'b1;
        end
    end
endmodule

// File: rtl/alu_instr_sequencer.sv
// Sequences one register-format instruction through IDLE/DECODE/EXECUTE/WRITEBACK and drives the datapath controls.
// Latency: accept-to-writeback-strobe 3 cycles; one instruction per 4 cycles.
// Backpressure: instrReady only in IDLE and not halted; ALU_SEQ_ILLEGAL_TRAP_EN makes illegal instructions halt until reset.
import alu_instr_sequencer_pkg::*;

module alu_instr_sequencer #(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 3,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_instr_sequencer_if.slave bus
);
    // Instructions arrive as datapath words and register fields are 4 bits wide
    if (REG_WIDTH < 16 || REG_ADDR_BITS < 1 || REG_ADDR_BITS > 4) begin : g_param_check
        $error("alu_instr_sequencer: unsupported REG_WIDTH/REG_ADDR_BITS");
    end

    seq_state_t               state;
    seq_state_t               state_next;
    logic [7:0]               instr_op;        // latched {opcode, opExt}
    logic [3:0]               alu_control;
    logic [REG_ADDR_BITS-1:0] reg_a;
    logic [REG_ADDR_BITS-1:0] reg_b;
    logic [COUNT_WIDTH-1:0]   retire_count;
    logic                     halted;
    logic                     accept;
    logic [3:0]               dec_opcode;
    logic [3:0]               dec_opext;
    decode_t                  dec;

    assign accept = bus.instrValid && bus.instrReady;

    // The decoder looks at the incoming word on the accept edge (so the control
    // word is registered into DECODE) and at the latched word afterwards.
    assign dec_opcode = accept ? bus.instr[15:12] : instr_op[7:4];
    assign dec_opext  = accept ? bus.instr[7:4]   : instr_op[3:0];

    alu_instr_decode u_decode (
        .opcode (dec_opcode),
        .opext  (dec_opext),
        .dec    (dec)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: fixed four-step walk, illegal instructions drop out of DECODE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = DECODE;
            DECODE:    state_next = dec.legal ? EXECUTE : IDLE;
            EXECUTE:   state_next = WRITEBACK;
            WRITEBACK: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output logic: handshake, status and single-cycle writeback strobes
    always_comb begin
        bus.instrReady      = (state == IDLE) && !halted;
        bus.busy            = (state != IDLE);
        bus.regWriteEnable  = (state == WRITEBACK) && dec.writes_reg;
        bus.flagWriteEnable = (state == WRITEBACK);
        bus.illegalInstr    = (state == DECODE) && !dec.legal;
    end

    // Instruction register and registered datapath controls, loaded on accept and held afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_op    <= '0;
            alu_control <= CONTROL_ADD;
            reg_a       <= '0;
            reg_b       <= '0;
        end else if (accept) begin
            instr_op <= {bus.instr[15:12], bus.instr[7:4]};
            reg_a    <= bus.instr[8 +: REG_ADDR_BITS];
            reg_b    <= bus.instr[0 +: REG_ADDR_BITS];
            // An illegal word leaves the previous control word on the bus
            if (dec.legal) alu_control <= dec.alu_control;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   retire_count <= '0;
        else if (state == WRITEBACK) retire_count <= retire_count + 1'b1;
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    // Sticky trap: an illegal instruction stops further accepts until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              halted <= 1'b0;
        else if (state == DECODE && !dec.legal) halted <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

    assign bus.aluControl  = alu_control;
    assign bus.regAddressA = reg_a;
    assign bus.regAddressB = reg_b;
    assign bus.retireCount = retire_count;
    assign bus.halted      = halted;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed self-checking bench for alu_instr_sequencer (COUNT_WIDTH=4 so counter wrap is reachable quickly).
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Honours ALU_SEQ_ILLEGAL_TRAP_EN for the illegal-instruction expectations.
module tb_alu_instr_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [3:0] exp_retire;

    alu_instr_sequencer_if #(.REG_ADDR_BITS(3), .COUNT_WIDTH(4)) bus ();

    alu_instr_sequencer #(
        .REG_WIDTH     (16),
        .REG_ADDR_BITS (3),
        .COUNT_WIDTH   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        bus.instrValid = 1'b0;
        bus.instr = 16'h0000;
        step();
        step();
        reset = 1'b0;
        exp_retire = 4'd0;
        #1;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({bus.instrReady, bus.busy, bus.aluControl, bus.regAddressA, bus.regAddressB,
             bus.regWriteEnable, bus.flagWriteEnable, bus.illegalInstr, bus.halted} !== {1'b1, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b busy=%b alu=%h a=%0d b=%0d we=%b fe=%b ill=%b halt=%b, required ready=1 others 0",
                     bus.instrReady, bus.busy, bus.aluControl, bus.regAddressA, bus.regAddressB,
                     bus.regWriteEnable, bus.flagWriteEnable, bus.illegalInstr, bus.halted);
        end
        checks++;
        if (bus.retireCount !== 4'd0) begin
            failures++;
            $display("FAIL reset_retire: got %0d required 0", bus.retireCount);
        end
    endtask

    task automatic test_add;
        checks++;
        if (bus.instrReady !== 1'b1) begin
            failures++;
            $display("FAIL add_ready_idle: got %b required 1", bus.instrReady);
        end
        bus.instrValid = 1'b1;
        bus.instr = 16'h0152;
        step();                       // DECODE
        bus.instrValid = 1'b0;
        checks++;
        if ({bus.aluControl, bus.regAddressA, bus.regAddressB} !== {4'b0000, 3'd1, 3'd2}) begin
            failures++;
            $display("FAIL add_decode_fields: alu=%b a=%0d b=%0d required alu=0000 a=1 b=2",
                     bus.aluControl, bus.regAddressA, bus.regAddressB);
        end
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (bus.instrReady !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL add_not_ready_cycle%0d: ready=%b busy=%b required ready=0 busy=1", c, bus.instrReady, bus.busy);
            end
            checks++;
            if ({bus.regWriteEnable, bus.flagWriteEnable} !== ((c == 3) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL add_strobes_cycle%0d: we=%b fe=%b required %b", c, bus.regWriteEnable,
                         bus.flagWriteEnable, (c == 3) ? 2'b11 : 2'b00);
            end
            if (c < 3) step();
        end
        step();                       // back to IDLE
        exp_retire = exp_retire + 4'd1;
        checks++;
        if ({bus.instrReady, bus.regWriteEnable, bus.flagWriteEnable, bus.retireCount} !== {1'b1, 1'b0, 1'b0, exp_retire}) begin
            failures++;
            $display("FAIL add_retire: ready=%b we=%b fe=%b count=%0d required ready=1 we=0 fe=0 count=%0d",
                     bus.instrReady, bus.regWriteEnable, bus.flagWriteEnable, bus.retireCount, exp_retire);
        end
    endtask

    task automatic test_cmp;
        bus.instrValid = 1'b1;
        bus.instr = 16'h03B4;
        step();                       // DECODE
        bus.instrValid = 1'b0;
        checks++;
        if ({bus.aluControl, bus.regAddressA, bus.regAddressB} !== {4'b0100, 3'd3, 3'd4}) begin
            failures++;
            $display("FAIL cmp_decode_fields: alu=%b a=%0d b=%0d required alu=0100 a=3 b=4",
                     bus.aluControl, bus.regAddressA, bus.regAddressB);
        end
        step();                       // EXECUTE
        step();                       // WRITEBACK
        checks++;
        if ({bus.regWriteEnable, bus.flagWriteEnable} !== 2'b01) begin
            failures++;
            $display("FAIL cmp_strobes: we=%b fe=%b required we=0 fe=1", bus.regWriteEnable, bus.flagWriteEnable);
        end
        step();
        exp_retire = exp_retire + 4'd1;
        checks++;
        if (bus.retireCount !== exp_retire) begin
            failures++;
            $display("FAIL cmp_retire: got %0d required %0d", bus.retireCount, exp_retire);
        end
    endtask

    task automatic test_back_to_back;
        bus.instrValid = 1'b1;
        bus.instr = 16'h8547;
        step();                       // DECODE of LSH
        bus.instr = 16'h0162;         // changed while busy, valid stays high
        checks++;
        if ({bus.aluControl, bus.regAddressA, bus.regAddressB} !== {4'b1000, 3'd5, 3'd7}) begin
            failures++;
            $display("FAIL b2b_lsh_fields: alu=%b a=%0d b=%0d required alu=1000 a=5 b=7",
                     bus.aluControl, bus.regAddressA, bus.regAddressB);
        end
        step();                       // EXECUTE
        step();                       // WRITEBACK
        checks++;
        if ({bus.aluControl, bus.regWriteEnable, bus.flagWriteEnable} !== {4'b1000, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL b2b_lsh_writeback: alu=%b we=%b fe=%b required alu=1000 we=1 fe=1",
                     bus.aluControl, bus.regWriteEnable, bus.flagWriteEnable);
        end
        step();                       // IDLE; held valid accepts on the next edge
        exp_retire = exp_retire + 4'd1;
        checks++;
        if ({bus.instrReady, bus.aluControl, bus.retireCount} !== {1'b1, 4'b1000, exp_retire}) begin
            failures++;
            $display("FAIL b2b_idle: ready=%b alu=%b count=%0d required ready=1 alu=1000 count=%0d",
                     bus.instrReady, bus.aluControl, bus.retireCount, exp_retire);
        end
        step();                       // DECODE of ADDU
        bus.instrValid = 1'b0;
        checks++;
        if ({bus.busy, bus.aluControl, bus.regAddressA, bus.regAddressB} !== {1'b1, 4'b0001, 3'd1, 3'd2}) begin
            failures++;
            $display("FAIL b2b_addu_fields: busy=%b alu=%b a=%0d b=%0d required busy=1 alu=0001 a=1 b=2",
                     bus.busy, bus.aluControl, bus.regAddressA, bus.regAddressB);
        end
        step();
        step();                       // WRITEBACK
        checks++;
        if (bus.regWriteEnable !== 1'b1) begin
            failures++;
            $display("FAIL b2b_addu_we: got %b required 1", bus.regWriteEnable);
        end
        step();
        exp_retire = exp_retire + 4'd1;
        checks++;
        if (bus.retireCount !== exp_retire) begin
            failures++;
            $display("FAIL b2b_retire: got %0d required %0d", bus.retireCount, exp_retire);
        end
    endtask

    task automatic test_illegal;
        bus.instrValid = 1'b1;
        bus.instr = 16'hF000;
        step();                       // DECODE
        bus.instrValid = 1'b0;
        checks++;
        if ({bus.illegalInstr, bus.busy, bus.regWriteEnable, bus.flagWriteEnable} !== 4'b1100) begin
            failures++;
            $display("FAIL illegal_decode: ill=%b busy=%b we=%b fe=%b required ill=1 busy=1 we=0 fe=0",
                     bus.illegalInstr, bus.busy, bus.regWriteEnable, bus.flagWriteEnable);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({bus.illegalInstr, bus.busy, bus.regWriteEnable, bus.flagWriteEnable, bus.retireCount} !== {4'b0000, exp_retire}) begin
                failures++;
                $display("FAIL illegal_after%0d: ill=%b busy=%b we=%b fe=%b count=%0d required all 0, count=%0d",
                         c, bus.illegalInstr, bus.busy, bus.regWriteEnable, bus.flagWriteEnable, bus.retireCount, exp_retire);
            end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            checks++;
            if ({bus.halted, bus.instrReady} !== 2'b10) begin
                failures++;
                $display("FAIL illegal_trap%0d: halted=%b ready=%b required halted=1 ready=0", c, bus.halted, bus.instrReady);
            end
`else
            checks++;
            if ({bus.halted, bus.instrReady} !== 2'b01) begin
                failures++;
                $display("FAIL illegal_drop%0d: halted=%b ready=%b required halted=0 ready=1", c, bus.halted, bus.instrReady);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_instr;
        apply_reset();
        bus.instrValid = 1'b1;
        bus.instr = 16'h0152;
        step();                       // DECODE
        bus.instrValid = 1'b0;
        step();                       // EXECUTE
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_busy_before: got %b required 1", bus.busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.instrReady, bus.busy, bus.aluControl, bus.regAddressA, bus.regAddressB,
             bus.regWriteEnable, bus.flagWriteEnable, bus.illegalInstr, bus.halted, bus.retireCount}
            !== {1'b1, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL midreset_outputs: ready=%b busy=%b alu=%h a=%0d b=%0d we=%b fe=%b ill=%b halt=%b count=%0d, required reset values",
                     bus.instrReady, bus.busy, bus.aluControl, bus.regAddressA, bus.regAddressB,
                     bus.regWriteEnable, bus.flagWriteEnable, bus.illegalInstr, bus.halted, bus.retireCount);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({bus.busy, bus.regWriteEnable, bus.retireCount} !== {1'b0, 1'b0, 4'd0}) begin
                failures++;
                $display("FAIL midreset_after%0d: busy=%b we=%b count=%0d required 0 0 0",
                         c, bus.busy, bus.regWriteEnable, bus.retireCount);
            end
        end
        exp_retire = 4'd0;
    endtask

    task automatic test_counter_wrap;
        logic [15:0] tv_instr [16];
        logic [3:0]  tv_alu   [16];
        logic [2:0]  tv_a     [16];
        logic [2:0]  tv_b     [16];
        logic        tv_wr    [16];
        tv_instr = '{16'h0152, 16'h0162, 16'h0293, 16'h03A4, 16'h04B5, 16'h0516, 16'h0627, 16'h0730,
                     16'h8041, 16'h0D5F, 16'h8C4A, 16'h0F9E, 16'h0B18, 16'h09B9, 16'h0E2C, 16'h0135};
        tv_alu   = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                     4'h8, 4'h0, 4'h8, 4'h2, 4'h5, 4'h4, 4'h6, 4'h7};
        tv_a     = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                     3'd0, 3'd5, 3'd4, 3'd7, 3'd3, 3'd1, 3'd6, 3'd1};
        tv_b     = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0,
                     3'd1, 3'd7, 3'd2, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5};
        tv_wr    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 16; i++) begin
            bus.instrValid = 1'b1;
            bus.instr = tv_instr[i];
            step();                   // DECODE
            bus.instrValid = 1'b0;
            checks++;
            if ({bus.aluControl, bus.regAddressA, bus.regAddressB} !== {tv_alu[i], tv_a[i], tv_b[i]}) begin
                failures++;
                $display("FAIL seq_fields[%0d] instr=%h: alu=%b a=%0d b=%0d required alu=%b a=%0d b=%0d",
                         i, tv_instr[i], bus.aluControl, bus.regAddressA, bus.regAddressB, tv_alu[i], tv_a[i], tv_b[i]);
            end
            step();
            step();                   // WRITEBACK
            checks++;
            if ({bus.regWriteEnable, bus.flagWriteEnable} !== {tv_wr[i], 1'b1}) begin
                failures++;
                $display("FAIL seq_strobes[%0d]: we=%b fe=%b required we=%b fe=1",
                         i, bus.regWriteEnable, bus.flagWriteEnable, tv_wr[i]);
            end
            step();
            exp_retire = exp_retire + 4'd1;
            checks++;
            if (bus.retireCount !== exp_retire) begin
                failures++;
                $display("FAIL seq_retire[%0d]: got %0d required %0d", i, bus.retireCount, exp_retire);
            end
        end
        checks++;
        if (bus.retireCount !== 4'd0) begin
            failures++;
            $display("FAIL counter_wrap: got %0d required 0", bus.retireCount);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_retire = 4'd0;
        reset = 1'b1;
        bus.instrValid = 1'b0;
        bus.instr = 16'h0000;
        test_reset();
        test_add();
        test_cmp();
        test_back_to_back();
        test_illegal();
        test_reset_mid_instr();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Hardware controller that accepts 16-bit register-format instructions over a valid/ready handshake. Decodes each one into the ALU control word and register file addresses/enables that currently come from bench stimulus. Sits in front of the cpu datapath (register file + ALU) and drives aluControl, regAddressA, regAddressB and the write enables. Fixed 4-state FSM per instruction; counts retired instructions.

Parameters:
REG_WIDTH, 16, datapath width (for consistency with cpu; not used for arithmetic here)
REG_ADDR_BITS, 3, register address width; instruction register fields truncated to this width
COUNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instrValid  in  1  instruction word present on instr
instr  in  16  instruction: [15:12] opcode, [11:8] Rdest, [7:4] opExt, [3:0] Rsrc
instrReady  out  1  sequencer can accept an instruction this cycle
aluControl  out  4  ALU control word to datapath
regAddressA  out  REG_ADDR_BITS  Rdest[REG_ADDR_BITS-1:0]; operand A and write destination
regAddressB  out  REG_ADDR_BITS  Rsrc[REG_ADDR_BITS-1:0]; operand B
regWriteEnable  out  1  one-cycle register file write strobe
flagWriteEnable  out  1  one-cycle PSR flag capture strobe
busy  out  1  instruction in flight (state != IDLE)
illegalInstr  out  1  one-cycle pulse on undecodable instruction
retireCount  out  COUNT_WIDTH  number of instructions retired (legal, reached WRITEBACK)
halted  out  1  sequencer halted by illegal trap (macro only; else constant 0)

Behaviour:
- Reset (async, active-high): state=IDLE; aluControl=4'b0000; regAddressA/B=0; regWriteEnable, flagWriteEnable, illegalInstr, halted=0; retireCount=0; instruction register cleared. Reset mid-instruction aborts it; no strobes issued; nothing retired.
- instrReady = (state==IDLE) && !halted. Accept occurs on the rising edge where instrValid && instrReady; instr is latched then. instrValid asserted while busy is ignored. Producer holds instr stable until accepted.
- States: IDLE -> DECODE on accept. DECODE -> EXECUTE if legal, else IDLE with illegalInstr pulse. EXECUTE -> WRITEBACK. WRITEBACK -> IDLE.
- aluControl and regAddressA/B are registered. They become valid in DECODE and are held through WRITEBACK. They retain their last value in IDLE.
- Decode, opcode 0000:
  - opExt 0101 ADD -> 0000
  - opExt 0110 ADDU -> 0001
  - opExt 1001 SUB -> 0010
  - opExt 1010 SUBU -> 0011
  - opExt 1011 CMP -> 0100
  - opExt 0001 AND -> 0101
  - opExt 0010 OR -> 0110
  - opExt 0011 XOR -> 0111
- Decode, opcode 1000, opExt 0100: LSH -> 1000.
- Any other opcode/opExt pair is illegal.
- WRITEBACK strobes (asserted exactly one cycle, only in WRITEBACK):
  - regWriteEnable=1 for all legal ops except CMP.
  - flagWriteEnable=1 for all legal ops.
- Throughput: one instruction per 4 cycles; next accept possible the cycle after WRITEBACK. Accept-to-strobe latency is 3 cycles.
- retireCount increments by 1 in WRITEBACK; wraps from 2^COUNT_WIDTH-1 to 0 silently.
- Register fields with bits above REG_ADDR_BITS set are truncated, not illegal.

Optional Feature:
ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction sets halted=1 in the cycle after DECODE. instrReady then stays 0 until reset; illegalInstr still pulses once.
- Undefined: illegal instructions are dropped (DECODE -> IDLE, illegalInstr pulse, retireCount unchanged); halted tied 0.

Decomposition:
- Shared package: ALU control localparams CONTROL_ADD..CONTROL_LSH (4'b0000..4'b1000), opcode/opExt encodings, FSM state encoding (IDLE, DECODE, EXECUTE, WRITEBACK).
- One sub-module: alu_instr_decode, a combinational map from {opcode, opExt} to {aluControl, writesReg, legal}. The FSM, instruction register and counter stay in the top.

Test Plan:
- Reset, then instr=16'h0152 (ADD R1,R2) with instrValid=1 for one cycle. Expect: instrReady=0 for 3 cycles; aluControl=0000, regAddressA=1, regAddressB=2 from DECODE; regWriteEnable=flagWriteEnable=1 exactly at cycle 3 after accept; retireCount=1.
- instr=16'h03B4 (CMP R3,R4). Expect aluControl=0100, flagWriteEnable pulse, regWriteEnable stays 0, retireCount increments.
- instr=16'h8547 (LSH R5,R7), with instrValid held high continuously and instr changed to 16'h0162 during busy. Expect LSH (1000) executed; 16'h0162 accepted only after WRITEBACK and executes as ADDU (0001).
- instr=16'hF000. Expect illegalInstr one-cycle pulse, no write strobes, retireCount unchanged. With the macro: halted=1 and instrReady=0 until reset.
- Assert reset during EXECUTE of 16'h0152. Expect immediate IDLE, all outputs at reset values, no regWriteEnable.
- Preload retireCount to 16'hFFFF via 65535 legal ops (or force); one more retire. Expect 16'h0000.
